// File: rtl/bullet_pkg.sv
// Shared types and screen bounds for the projectile pool.
package bullet_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    localparam int POS_W     = 10;
    localparam int X_MAX_DEF = 639;
    localparam int Y_MAX_DEF = 479;

endpackage

// File: rtl/bullet_slot.sv
// One projectile slot: position, latched direction and valid, with move/retire per frame.
// Load wins over move; a freshly loaded bullet sits still on its load edge.
module bullet_slot
    import bullet_pkg::*;
#(
    parameter int BULLET_STEP = 4,
    parameter int X_MAX       = X_MAX_DEF,
    parameter int Y_MAX       = Y_MAX_DEF
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       load,
    input  logic [9:0] load_x,
    input  logic [9:0] load_y,
    input  logic [1:0] load_dir,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic       valid
);

    localparam logic [10:0] STEP11 = 11'(BULLET_STEP);
    localparam logic [9:0]  STEP10 = 10'(BULLET_STEP);
    localparam logic [10:0] XLIM   = 11'(X_MAX);
    localparam logic [10:0] YLIM   = 11'(Y_MAX);

    dir_t        dir;
    logic [10:0] x_ext;
    logic [10:0] y_ext;
    logic        retire;
    logic [9:0]  next_x;
    logic [9:0]  next_y;

    assign x_ext = {1'b0, pos_x};
    assign y_ext = {1'b0, pos_y};

    // Bounds are checked one bit wider so the step can never wrap past 0 or 1023.
    always_comb begin
        retire = 1'b0;
        next_x = pos_x;
        next_y = pos_y;
        case (dir)
            DIR_UP:    if (y_ext < STEP11)         retire = 1'b1; else next_y = pos_y - STEP10;
            DIR_DOWN:  if (y_ext + STEP11 > YLIM)  retire = 1'b1; else next_y = pos_y + STEP10;
            DIR_LEFT:  if (x_ext < STEP11)         retire = 1'b1; else next_x = pos_x - STEP10;
            default:   if (x_ext + STEP11 > XLIM)  retire = 1'b1; else next_x = pos_x + STEP10;
        endcase
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            pos_x <= '0;
            pos_y <= '0;
            dir   <= DIR_UP;
            valid <= 1'b0;
        end else if (load) begin
            pos_x <= load_x;
            pos_y <= load_y;
            dir   <= dir_t'(load_dir);
            valid <= 1'b1;
        end else if (valid) begin
            if (retire) begin
                valid <= 1'b0;
            end else begin
                pos_x <= next_x;
                pos_y <= next_y;
            end
        end
    end

endmodule

// File: rtl/bullet_pool.sv
// Projectile pool: spawns from the ship into the lowest free slot, rate-limited by a cooldown.
// All outputs registered, one frame from inputs; a full pool drops the fire request.
module bullet_pool
    import bullet_pkg::*;
#(
    parameter int NUM_BULLETS = 4,
    parameter int BULLET_STEP = 4,
    parameter int COOLDOWN    = 8,
    parameter int X_MAX       = X_MAX_DEF,
    parameter int Y_MAX       = Y_MAX_DEF
) (
    input  logic                      frame_clk,
    input  logic                      Reset,
    input  logic                      fire,
    input  logic [9:0]                ShipX,
    input  logic [9:0]                ShipY,
    input  logic [1:0]                ShipDir,
    output logic [10*NUM_BULLETS-1:0] BulletX,
    output logic [10*NUM_BULLETS-1:0] BulletY,
    output logic [NUM_BULLETS-1:0]    BulletValid,
    output logic                      CooldownBusy
);

    localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    logic [CW-1:0]          cooldown;
    logic [CW-1:0]          cooldown_next;
    logic [NUM_BULLETS-1:0] first_free;
    logic [NUM_BULLETS-1:0] load;
    logic                   found;
    logic                   spawn;

    // Slot valids are sampled before the edge, so a slot retiring now stays unavailable.
    always_comb begin
        first_free = '0;
        found      = 1'b0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (!BulletValid[i] && !found) begin
                first_free[i] = 1'b1;
                found         = 1'b1;
            end
        end
    end

    assign spawn = fire && (cooldown == '0) && found;
    assign load  = spawn ? first_free : '0;

    always_comb begin
        cooldown_next = cooldown;
        if (spawn)
            cooldown_next = CW'(COOLDOWN);
        else if (cooldown != '0)
            cooldown_next = cooldown - CW'(1);
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            cooldown     <= '0;
            CooldownBusy <= 1'b0;
        end else begin
            cooldown     <= cooldown_next;
            CooldownBusy <= (cooldown_next != '0);
        end
    end

    for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
        bullet_slot #(
            .BULLET_STEP (BULLET_STEP),
            .X_MAX       (X_MAX),
            .Y_MAX       (Y_MAX)
        ) u_slot (
            .frame_clk (frame_clk),
            .Reset     (Reset),
            .load      (load[g]),
            .load_x    (ShipX),
            .load_y    (ShipY),
            .load_dir  (ShipDir),
            .pos_x     (BulletX[10*g +: 10]),
            .pos_y     (BulletY[10*g +: 10]),
            .valid     (BulletValid[g])
        );
    end

endmodule

// File: tb/tb_bullet_pool.sv
// Bench for bullet_pool: directed table, hand-written corner sequences, random vs. pool model.
module tb_bullet_pool;

    logic        frame_clk = 1'b0;
    logic        Reset     = 1'b1;
    logic        fire      = 1'b0;
    logic [9:0]  ship_x    = '0;
    logic [9:0]  ship_y    = '0;
    logic [1:0]  ship_dir  = '0;

    logic [39:0] bx, by, bx0, by0;
    logic [3:0]  bv, bv0;
    logic        busy, busy0;

    int checks = 0;
    int errors = 0;

    always #5 frame_clk = ~frame_clk;

    bullet_pool dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .fire         (fire),
        .ShipX        (ship_x),
        .ShipY        (ship_y),
        .ShipDir      (ship_dir),
        .BulletX      (bx),
        .BulletY      (by),
        .BulletValid  (bv),
        .CooldownBusy (busy)
    );

    bullet_pool #(.COOLDOWN(0)) dut0 (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .fire         (fire),
        .ShipX        (ship_x),
        .ShipY        (ship_y),
        .ShipDir      (ship_dir),
        .BulletX      (bx0),
        .BulletY      (by0),
        .BulletValid  (bv0),
        .CooldownBusy (busy0)
    );

    // Pool model for the default-parameter instance: plain arrays of bullets.
    int mx[4], my[4], md[4];
    bit mv[4];
    int mcd;

    typedef struct {
        bit rst;
        bit fire;
        int sx, sy, dir;
        int ev, ex0, ey0, ebusy;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mx[i] = 0; my[i] = 0; md[i] = 0; mv[i] = 0;
        end
        mcd = 0;
    endtask

    task automatic model_step();
        int idx;
        bit spawn;
        idx = -1;
        for (int i = 0; i < 4; i++)
            if (!mv[i] && idx < 0) idx = i;
        spawn = fire && (mcd == 0) && (idx >= 0);
        for (int i = 0; i < 4; i++) begin
            if (mv[i]) begin
                case (md[i])
                    0: if (my[i] - 4 < 0)   mv[i] = 0; else my[i] = my[i] - 4;
                    1: if (my[i] + 4 > 479) mv[i] = 0; else my[i] = my[i] + 4;
                    2: if (mx[i] - 4 < 0)   mv[i] = 0; else mx[i] = mx[i] - 4;
                    default: if (mx[i] + 4 > 639) mv[i] = 0; else mx[i] = mx[i] + 4;
                endcase
            end
        end
        if (spawn) begin
            mx[idx] = ship_x; my[idx] = ship_y; md[idx] = ship_dir; mv[idx] = 1;
            mcd = 8;
        end else if (mcd > 0) begin
            mcd = mcd - 1;
        end
    endtask

    task automatic check_model(input string tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s valid%0d", tag, i), int'(bv[i]), int'(mv[i]));
            check($sformatf("%s x%0d", tag, i), int'(bx[10*i +: 10]), mx[i]);
            check($sformatf("%s y%0d", tag, i), int'(by[10*i +: 10]), my[i]);
        end
        check($sformatf("%s busy", tag), int'(busy), int'(mcd != 0));
    endtask

    task automatic tick(input string tag);
        @(posedge frame_clk);
        model_step();
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        fire  = 1'b0;
        Reset = 1'b1;
        model_reset();
        #2;
        Reset = 1'b0;
    endtask

    initial begin
        // rst, fire, x, y, dir, exp valid, exp x0, exp y0, exp busy
        tbl.push_back('{1, 1, 320, 240, 0, 1, 320, 240, 1});
        tbl.push_back('{0, 0, 320, 240, 0, 1, 320, 236, 1});
        tbl.push_back('{0, 0, 320, 240, 0, 1, 320, 232, 1});
        tbl.push_back('{1, 1, 630, 100, 3, 1, 630, 100, 1});
        tbl.push_back('{0, 0, 630, 100, 3, 1, 634, 100, 1});
        tbl.push_back('{0, 0, 630, 100, 3, 1, 638, 100, 1});
        tbl.push_back('{0, 0, 630, 100, 3, 0, 638, 100, 1});
        tbl.push_back('{0, 0, 630, 100, 3, 0, 638, 100, 1});
        tbl.push_back('{0, 0, 630, 100, 3, 0, 638, 100, 1});
        tbl.push_back('{0, 0, 630, 100, 3, 0, 638, 100, 1});
        tbl.push_back('{0, 0, 630, 100, 3, 0, 638, 100, 1});
        tbl.push_back('{0, 0, 630, 100, 3, 0, 638, 100, 0});
        tbl.push_back('{0, 1,  10,  20, 2, 1,  10,  20, 1});

        do_reset();
        check("reset valid", int'(bv), 0);
        check("reset busy", int'(busy), 0);
        check_model("reset");

        foreach (tbl[r]) begin
            if (tbl[r].rst) do_reset();
            fire     = tbl[r].fire;
            ship_x   = 10'(tbl[r].sx);
            ship_y   = 10'(tbl[r].sy);
            ship_dir = 2'(tbl[r].dir);
            tick($sformatf("tbl%0d", r));
            check($sformatf("tbl%0d valid", r), int'(bv), tbl[r].ev);
            check($sformatf("tbl%0d x0", r), int'(bx[9:0]), tbl[r].ex0);
            check($sformatf("tbl%0d y0", r), int'(by[9:0]), tbl[r].ey0);
            check($sformatf("tbl%0d busy", r), int'(busy), tbl[r].ebusy);
        end

        // Fire held for 40 frames: four spawns nine frames apart, then a full pool.
        do_reset();
        fire = 1'b1; ship_x = 10'd320; ship_y = 10'd240; ship_dir = 2'd0;
        for (int e = 0; e < 40; e++) begin
            tick($sformatf("hold%0d", e));
            case (e)
                0:  check("hold e0 valid", int'(bv), 4'h1);
                8:  check("hold e8 valid", int'(bv), 4'h1);
                9:  check("hold e9 valid", int'(bv), 4'h3);
                18: check("hold e18 valid", int'(bv), 4'h7);
                27: check("hold e27 valid", int'(bv), 4'hF);
                36: begin
                    check("hold e36 valid", int'(bv), 4'hF);
                    check("hold e36 busy", int'(busy), 0);
                end
                39: check("hold e39 busy", int'(busy), 0);
                default: ;
            endcase
        end

        // Asynchronous reset mid-flight: three bullets up, cooldown at 5.
        do_reset();
        fire = 1'b1; ship_x = 10'd320; ship_y = 10'd240; ship_dir = 2'd0;
        repeat (22) tick("pre");
        check("pre-reset active", $countones(bv), 3);
        check("pre-reset busy", int'(busy), 1);
        Reset = 1'b1;
        #1;
        check("async valid", int'(bv), 0);
        check("async x", (bx == '0) ? 1 : 0, 1);
        check("async y", (by == '0) ? 1 : 0, 1);
        check("async busy", int'(busy), 0);
        Reset = 1'b0;
        fire  = 1'b0;
        model_reset();
        #1;

        // COOLDOWN=0: retire at top edge, the freed slot0 is reused one edge later.
        do_reset();
        fire = 1'b1; ship_x = 10'd320; ship_y = 10'd2; ship_dir = 2'd0;
        tick("cd0 e0");
        check("cd0 e0 valid", int'(bv0), 4'h1);
        tick("cd0 e1");
        check("cd0 e1 valid", int'(bv0), 4'h2);
        check("cd0 e1 y0 held", int'(by0[9:0]), 2);
        ship_x = 10'd100;
        tick("cd0 e2");
        check("cd0 e2 valid", int'(bv0), 4'h1);
        check("cd0 e2 x0", int'(bx0[9:0]), 100);
        check("cd0 busy", int'(busy0), 0);

        // Slot0 retires on the same edge fire meets a full pool.
        do_reset();
        fire = 1'b1; ship_x = 10'd50; ship_y = 10'd13; ship_dir = 2'd0;
        tick("full e0");
        ship_y = 10'd240;
        repeat (3) tick("full e1-3");
        check("full e3 valid", int'(bv0), 4'hF);
        check("full e3 y0", int'(by0[9:0]), 1);
        tick("full e4");
        check("full e4 valid", int'(bv0), 4'hE);
        check("full e4 y0", int'(by0[9:0]), 1);
        tick("full e5");
        check("full e5 valid", int'(bv0), 4'hF);
        check("full e5 y0", int'(by0[9:0]), 240);

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            fire     = ($urandom_range(0, 2) != 0);
            ship_x   = 10'($urandom_range(0, 639));
            ship_y   = 10'($urandom_range(0, 479));
            ship_dir = 2'($urandom_range(0, 3));
            tick($sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bullet_pool.md
Name: bullet_pool

Overview:
- Downstream consumer of the ship movement stage. Takes ship position, facing direction and a fire request each frame; manages a fixed pool of projectiles.
- Spawns projectiles at the ship position, moves each one per frame, and retires it at the screen edge.
- Outputs registered per-slot positions and valid flags to the colour mapper / sprite renderer.

Parameters:
NUM_BULLETS, 4, number of projectile slots
BULLET_STEP, 4, pixels moved per frame (unsigned, 1..15)
COOLDOWN, 8, frames between spawns while fire is held (0 = spawn every frame)
X_MAX, 639, rightmost legal X
Y_MAX, 479, bottommost legal Y

Ports:
frame_clk  in  1  frame-rate clock (one rising edge per frame)
Reset  in  1  asynchronous reset, active-high
fire  in  1  fire key held (level, decoded upstream from keycode)
ShipX  in  10  current ship X
ShipY  in  10  current ship Y
ShipDir  in  2  ship facing direction: 00 up, 01 down, 10 left, 11 right
BulletX  out  10*NUM_BULLETS  slot i X at bits [10i+9:10i]
BulletY  out  10*NUM_BULLETS  slot i Y at bits [10i+9:10i]
BulletValid  out  NUM_BULLETS  slot i active
CooldownBusy  out  1  cooldown counter nonzero

Behaviour:
- Interface: reset Reset, asynchronous, active-high; clock frame_clk.
- Reset: all BulletValid=0, BulletX/BulletY=0, stored directions=00, cooldown=0, CooldownBusy=0. Reset takes effect immediately, including mid-flight.
- Each frame_clk edge evaluates move, spawn and cooldown in parallel, using values sampled before the edge.
- Move: each valid slot advances BULLET_STEP in its stored direction.
  - Boundary checks are computed in 11 bits, so there is no wrap.
  - Retire (valid<=0, position held) if the next position would be illegal: up when Y<BULLET_STEP; down when Y+BULLET_STEP>Y_MAX; left when X<BULLET_STEP; right when X+BULLET_STEP>X_MAX.
- Spawn condition: fire=1, cooldown==0, and at least one slot has valid==0 before the edge.
  - A slot retiring on this edge is not reusable until the next edge.
- On spawn:
  - The lowest-index free slot loads ShipX, ShipY and ShipDir, and sets valid=1.
  - The spawned bullet does not move on its spawn edge.
  - cooldown<=COOLDOWN.
- No free slot: the fire request is dropped and the cooldown is not loaded.
- Cooldown: decrement by 1 per edge when nonzero and no spawn occurs.
  - With fire held, spawns occur at edges t, t+COOLDOWN+1, and so on.
- Direction is latched per slot at spawn; later ShipDir changes do not affect bullets in flight.
- All outputs are registered; output latency is one edge from inputs.

Decomposition:
- Package bullet_pkg:
  - dir_t enum: DIR_UP=2'b00, DIR_DOWN=2'b01, DIR_LEFT=2'b10, DIR_RIGHT=2'b11.
  - Default screen bound constants 639/479.
- Sub-module bullet_slot: one slot's X/Y/dir/valid registers plus its move and retire logic, with a load strobe.
  - Instantiated NUM_BULLETS times via generate.
- Top level holds the free-slot priority encoder and the cooldown counter.

Test Plan:
- Reset asserted with 3 active slots and cooldown=5 -> all BulletValid=0, BulletX/Y=0 and CooldownBusy=0 immediately, with no clock edge needed.
- ShipX=320, ShipY=240, ShipDir=UP, fire for 1 frame -> after edge 0: slot0 valid at (320,240); after edges 1 and 2: Y=236, then Y=232; CooldownBusy=1 for 8 edges.
- fire held for 40 frames, defaults -> spawns at edges 0, 9, 18, 27 into slots 0..3; at edge 36 the pool is full, no spawn occurs, and cooldown stays 0.
- Spawn ShipDir=RIGHT at X=630 -> X=634, then 638, then retire at the third edge (642>639); slot0 becomes free and the next fire reuses slot0.
- Spawn ShipDir=UP at Y=2 -> BulletValid[0] clears on the next edge and Y holds at 2; with COOLDOWN=0 and fire held, a new spawn lands in slot0 on the following edge.
- Slot0 retiring on the same edge fire arrives with slots 1..3 full -> no spawn on that edge; spawn lands in slot0 one edge later.
